fetch_unit: RTL and testbench

Instruction fetch front end that produces the instruction stream consumed by the decoder. It issues sequential reads to instruction memory and buffers returned words with their PCs in a small FIFO. It presents the head entry to decode over a valid/ready handshake, split into opcode, funct3 and funct7. A redirect (taken branch or jump) flushes the buffer, and any in-flight memory read is completed and discarded.

---
 rtl/fetch_unit_pkg.sv | 35 +++
 rtl/fetch_fifo.sv | 66 ++++++
 rtl/fetch_unit.sv | 114 +++++++++++
 tb/tb_fetch_unit.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction fetch front end: FSM states, buffered
// fetch entries and the RV32I major opcode encoding seen by decode.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_FENCE  = 7'b0001111,
    OP_IMM    = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_REG    = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111,
    OP_SYSTEM = 7'b1110011
  } rv32i_opcode;

  // Fetch addresses are always word aligned; the low two bits are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries. Flush empties it in one cycle and
// takes priority over push and pop.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  fetch_entry_t               wr_entry,
  output fetch_entry_t               rd_entry,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           push_ok;
  logic           pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & ~full;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values that were present before the clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; nothing reads an entry before it
  // is written, and the consumer gates the head with the empty flag.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= wr_entry;
  end

  assign rd_entry = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding sequential read at a time,
// responses buffered with their PCs and handed to decode over valid/ready.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h40000060
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output rv32i_opcode dec_opcode,
  output logic [2:0]  dec_funct3,
  output logic [6:0]  dec_funct7
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  fetch_state_t  state;
  logic [31:0]   fetch_pc;
  logic [31:0]   inflight_addr;

  fetch_entry_t  head;
  fetch_entry_t  new_entry;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;

  // Redirect beats both a pop and a push in the same cycle.
  assign pop        = dec_valid & dec_ready & ~redirect;
  assign push       = imem_resp & (state == FETCH) & ~redirect;
  assign count_next = count + CW'(push) - CW'(pop);
  assign new_entry  = '{pc: fetch_pc, instr: imem_rdata};

  fetch_fifo #(
    .DEPTH    (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .flush    (redirect),
    .wr_entry (new_entry),
    .rd_entry (head),
    .count    (count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      fetch_pc      <= RESET_PC;
      inflight_addr <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (redirect) begin
            fetch_pc <= align_pc(redirect_pc);
            state    <= FETCH;
          end else if (!fifo_full || pop) begin
            state <= FETCH;
          end
        end

        FETCH: begin
          if (redirect) begin
            fetch_pc <= align_pc(redirect_pc);
            // The read already on the bus must still be completed; park its
            // address so the request stays stable while it drains.
            if (!imem_resp) begin
              inflight_addr <= fetch_pc;
              state         <= DISCARD;
            end
          end else if (imem_resp) begin
            fetch_pc <= fetch_pc + 32'd4;
            if (count_next >= FULL_COUNT) state <= IDLE;
          end
        end

        DISCARD: begin
          if (redirect)  fetch_pc <= align_pc(redirect_pc);
          if (imem_resp) state    <= FETCH;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign imem_read    = (state != IDLE);
  assign imem_address = (state == DISCARD) ? inflight_addr : fetch_pc;

  assign dec_valid  = ~fifo_empty;
  assign dec_instr  = dec_valid ? head.instr : '0;
  assign dec_pc     = dec_valid ? head.pc    : '0;
  assign dec_opcode = rv32i_opcode'(dec_instr[6:0]);
  assign dec_funct3 = dec_instr[14:12];
  assign dec_funct7 = dec_instr[31:25];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a queue-based reference model of the fetch stream,
// a latency-programmable memory, directed scenarios and a random phase.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h40000060;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] imem_rdata = '0;
  logic        imem_resp = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  rv32i_opcode dec_opcode;
  logic [2:0]  dec_funct3;
  logic [6:0]  dec_funct7;

  always #5 clk = ~clk;

  fetch_unit #(
    .DEPTH        (DEPTH),
    .RESET_PC     (RESET_PC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_read    (imem_read),
    .imem_address (imem_address),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .dec_valid    (dec_valid),
    .dec_ready    (dec_ready),
    .dec_instr    (dec_instr),
    .dec_pc       (dec_pc),
    .dec_opcode   (dec_opcode),
    .dec_funct3   (dec_funct3),
    .dec_funct7   (dec_funct7)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: buffered entries, whether a read is on the bus, whether
  // its data will be dropped, the address on the bus and the next fetch PC.
  fetch_entry_t m_q[$];
  bit           m_reading;
  bit           m_discard;
  logic [31:0]  m_addr;
  logic [31:0]  m_pc;

  // Memory behaviour: respond after cur_lat idle request cycles.
  int wait_cnt   = 0;
  int cur_lat    = 0;
  int lat_min    = 0;
  int lat_max    = 0;
  bit fixed_data = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_reading = 1'b0;
    m_discard = 1'b0;
    m_pc      = RESET_PC;
    m_addr    = RESET_PC;
  endtask

  // Advance the model across one rising edge with the inputs of that cycle.
  task automatic model_step(input bit resp, input logic [31:0] rdata, input bit redir,
                            input logic [31:0] rpc, input bit ready);
    bit           pop;
    fetch_entry_t e;
    pop = (m_q.size() != 0) && ready && !redir;
    if (redir) begin
      m_q.delete();
      m_pc = rpc & ~32'h3;
      if (m_reading && !resp) begin
        m_discard = 1'b1;
      end else begin
        m_reading = 1'b1;
        m_discard = 1'b0;
        m_addr    = m_pc;
      end
    end else begin
      if (pop) void'(m_q.pop_front());
      if (!m_reading || resp) begin
        if (m_reading && !m_discard) begin
          e.pc    = m_addr;
          e.instr = rdata;
          m_q.push_back(e);
          m_pc = m_addr + 32'd4;
        end
        m_discard = 1'b0;
        m_reading = (m_q.size() < DEPTH);
        if (m_reading) m_addr = m_pc;
      end
    end
  endtask

  task automatic compare_model();
    check("imem_read", 64'(imem_read), 64'(m_reading));
    if (m_reading) check("imem_address", 64'(imem_address), 64'(m_addr));
    check("dec_valid", 64'(dec_valid), 64'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      check("dec_pc",     64'(dec_pc),     64'(m_q[0].pc));
      check("dec_instr",  64'(dec_instr),  64'(m_q[0].instr));
      check("dec_opcode", 64'(dec_opcode), 64'(m_q[0].instr[6:0]));
      check("dec_funct3", 64'(dec_funct3), 64'(m_q[0].instr[14:12]));
      check("dec_funct7", 64'(dec_funct7), 64'(m_q[0].instr[31:25]));
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    compare_model();
  endtask

  // Drive one cycle of inputs (memory answers only an asserted request).
  task automatic apply(input bit ready, input bit redir, input logic [31:0] rpc);
    bit          resp;
    logic [31:0] d;
    resp = 1'b0;
    d    = fixed_data ? 32'h00000013 : $urandom;
    if (imem_read) begin
      if (wait_cnt >= cur_lat) begin
        resp     = 1'b1;
        wait_cnt = 0;
        cur_lat  = int'($urandom_range(lat_max, lat_min));
      end else begin
        wait_cnt++;
      end
    end
    imem_resp   = resp;
    imem_rdata  = resp ? d : $urandom;
    dec_ready   = ready;
    redirect    = redir;
    redirect_pc = rpc;
    model_step(resp, d, redir, rpc, ready);
  endtask

  initial begin
    bit          got_setup;
    int          ready_pct;
    bit          rdy;
    bit          rdr;
    logic [31:0] rpc;

    model_reset();
    #2;
    check("rst_imem_read", 64'(imem_read), 64'(0));
    check("rst_dec_valid", 64'(dec_valid), 64'(0));
    check("rst_dec_instr", 64'(dec_instr), 64'(0));
    check("rst_dec_pc",    64'(dec_pc),    64'(0));
    check("rst_opcode",    64'(dec_opcode), 64'(0));

    @(negedge clk);
    compare_model();
    rst = 1'b1;
    apply(1'b1, 1'b0, '0);

    // Sequential stream from RESET_PC with a 1-cycle memory.
    at_neg();
    check("t1_read0", 64'(imem_read), 64'(1));
    check("t1_addr0", 64'(imem_address), 64'h40000060);
    check("t1_valid0", 64'(dec_valid), 64'(0));
    apply(1'b1, 1'b0, '0);
    at_neg();
    check("t1_addr1", 64'(imem_address), 64'h40000064);
    check("t1_pc0", 64'(dec_pc), 64'h40000060);
    check("t1_opcode", 64'(dec_opcode), 64'h13);
    check("t1_funct3", 64'(dec_funct3), 64'h0);
    apply(1'b1, 1'b0, '0);
    at_neg();
    check("t1_addr2", 64'(imem_address), 64'h40000068);
    check("t1_pc1", 64'(dec_pc), 64'h40000064);
    apply(1'b1, 1'b0, '0);

    // Decode stalls: buffer fills to DEPTH and fetching stops.
    repeat (10) begin
      at_neg();
      apply(1'b0, 1'b0, '0);
    end
    at_neg();
    check("t2_model_count", 64'(m_q.size()), 64'(4));
    check("t2_read_idle", 64'(imem_read), 64'(0));
    check("t2_head_pc", 64'(dec_pc), 64'h40000068);
    apply(1'b1, 1'b0, '0);
    at_neg();
    check("t2_one_read", 64'(imem_read), 64'(1));
    check("t2_one_addr", 64'(imem_address), 64'h40000078);
    apply(1'b0, 1'b0, '0);
    at_neg();
    check("t2_idle_again", 64'(imem_read), 64'(0));
    apply(1'b0, 1'b0, '0);
    at_neg();
    check("t2_still_idle", 64'(imem_read), 64'(0));
    cur_lat = 3;
    lat_min = 3;
    lat_max = 3;
    apply(1'b1, 1'b0, '0);

    // Redirect while a slow read is outstanding.
    at_neg();
    check("t3_read", 64'(imem_read), 64'(1));
    check("t3_addr", 64'(imem_address), 64'h4000007c);
    lat_min = 0;
    lat_max = 0;
    apply(1'b0, 1'b1, 32'h40000100);
    at_neg();
    check("t3_hold_b", 64'(imem_address), 64'h4000007c);
    check("t3_flushed", 64'(dec_valid), 64'(0));
    apply(1'b0, 1'b0, '0);
    at_neg();
    check("t3_hold_c", 64'(imem_address), 64'h4000007c);
    apply(1'b0, 1'b0, '0);
    at_neg();
    check("t3_hold_d", 64'(imem_address), 64'h4000007c);
    apply(1'b0, 1'b0, '0);
    at_neg();
    check("t3_new_addr", 64'(imem_address), 64'h40000100);
    check("t3_dropped", 64'(dec_valid), 64'(0));
    apply(1'b0, 1'b0, '0);
    at_neg();
    check("t3_first_pc", 64'(dec_pc), 64'h40000100);
    apply(1'b1, 1'b0, '0);
    repeat (3) begin
      at_neg();
      apply(1'b1, 1'b0, '0);
    end

    // Redirect coinciding with a response, to an unaligned target.
    at_neg();
    check("t4_read", 64'(imem_read), 64'(1));
    apply(1'b1, 1'b1, 32'h40000203);
    at_neg();
    check("t4_addr", 64'(imem_address), 64'h40000200);
    check("t4_no_push", 64'(dec_valid), 64'(0));
    apply(1'b1, 1'b0, '0);
    at_neg();
    check("t4_pc", 64'(dec_pc), 64'h40000200);
    apply(1'b1, 1'b0, '0);

    // Asynchronous reset while a read is outstanding and two entries wait.
    fixed_data = 1'b0;
    lat_min    = 2;
    lat_max    = 2;
    got_setup  = 1'b0;
    for (int i = 0; i < 40 && !got_setup; i++) begin
      at_neg();
      apply(1'b0, 1'b0, '0);
      got_setup = (m_q.size() == 2) && m_reading;
    end
    check("t6_setup", 64'(got_setup), 64'(1));
    @(posedge clk);
    #1;
    check("t6_pre_read", 64'(imem_read), 64'(1));
    check("t6_pre_valid", 64'(dec_valid), 64'(1));
    #1;
    rst = 1'b0;
    #1;
    check("t6_read_drop", 64'(imem_read), 64'(0));
    check("t6_valid_drop", 64'(dec_valid), 64'(0));
    check("t6_instr_zero", 64'(dec_instr), 64'(0));
    model_reset();
    wait_cnt  = 0;
    cur_lat   = 0;
    lat_min   = 0;
    lat_max   = 0;
    imem_resp = 1'b0;
    dec_ready = 1'b0;
    redirect  = 1'b0;
    at_neg();
    rst = 1'b1;
    apply(1'b1, 1'b0, '0);
    at_neg();
    check("t6_restart_read", 64'(imem_read), 64'(1));
    check("t6_restart_addr", 64'(imem_address), 64'h40000060);
    apply(1'b1, 1'b0, '0);

    // Random traffic: varying decode pressure, latency and redirects.
    lat_max   = 3;
    ready_pct = 90;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        unique case ((c / 200) % 3)
          0:       ready_pct = 90;
          1:       ready_pct = 50;
          default: ready_pct = 10;
        endcase
      end
      at_neg();
      rdy = ($urandom_range(99) < ready_pct);
      rdr = ($urandom_range(99) < 4);
      rpc = $urandom;
      if ($urandom_range(7) == 0) rpc = 32'hfffffff0 | (rpc & 32'hf);
      apply(rdy, rdr, rpc);
    end
    at_neg();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
